// File: rtl/classifier_window_sequencer.sv
// ---------------------------------------------------------------------------
// classifier_window_sequencer
//
// Scan controller for the WIN x WIN integral-window classifier. Walks a
// window across the frame in raster order with step STRIDE on both axes.
// For each window row it streams WIN pixels out of frame memory into the
// classifier line buffer (addresses 0..WIN-1), pulses cls_start, and waits
// for cls_done before loading the next row. One start per frame.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start         frame start request, honoured only in IDLE
//   mem_rd        frame memory read strobe
//   mem_addr      frame memory pixel address
//   mem_data      frame memory read data, valid one cycle after mem_rd
//   cls_we        line-buffer write strobe
//   cls_addr      line-buffer write address, 0..WIN-1
//   cls_xyz       line-buffer write data
//   cls_start     one-cycle pulse once a full row is in the line buffer
//   cls_done      classifier finished the current row (level)
//   win_x, win_y  current window top-left corner
//   row_idx       current row within the window
//   busy          high in every state except IDLE
//   frame_done    one-cycle pulse after the last row of the last window
// ---------------------------------------------------------------------------
module classifier_window_sequencer #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int WIN    = 20,
    parameter int STRIDE = 4,
    parameter int MEM_AW = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [95:0]       mem_data,
    output logic              cls_we,
    output logic [8:0]        cls_addr,
    output logic [95:0]       cls_xyz,
    output logic              cls_start,
    input  logic              cls_done,
    output logic [15:0]       win_x,
    output logic [15:0]       win_y,
    output logic [4:0]        row_idx,
    output logic              busy,
    output logic              frame_done
);

    // Parameter sanity: the window must fit the frame, row/column counters
    // are 5 bits wide, and the address width must cover the whole frame.
    if (IMG_W < WIN || IMG_H < WIN) begin : g_bad_frame
        $error("classifier_window_sequencer: frame smaller than window");
    end
    if (WIN < 1 || WIN > 32) begin : g_bad_win
        $error("classifier_window_sequencer: WIN must be 1..32");
    end
    if (STRIDE < 1) begin : g_bad_stride
        $error("classifier_window_sequencer: STRIDE must be positive");
    end
    if (MEM_AW > 32 || (64'(IMG_W) * 64'(IMG_H)) > (64'd1 << MEM_AW)) begin : g_bad_aw
        $error("classifier_window_sequencer: MEM_AW too narrow for frame");
    end

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        KICK,
        WAIT,
        ADVANCE,
        FIN
    } state_t;

    localparam logic [4:0]        COL_LAST = 5'(WIN - 1);
    localparam logic [15:0]       STEP     = 16'(STRIDE);
    localparam logic [MEM_AW-1:0] LINE_W   = MEM_AW'(IMG_W);

    state_t            state;
    state_t            state_n;
    logic [4:0]        col;
    logic [MEM_AW-1:0] base;
    logic              wr_pending;
    logic [4:0]        wr_col;

    logic              row_last;
    logic              fits_x;
    logic              fits_y;
    logic              frame_end;
    logic [4:0]        row_n;
    logic [15:0]       win_x_n;
    logic [15:0]       win_y_n;
    logic [MEM_AW-1:0] base_n;

    // Next window position and row base, evaluated for use in ADVANCE.
    // A step is taken only if the whole shifted window still fits the frame.
    always_comb begin
        row_last  = (row_idx == COL_LAST);
        fits_x    = ({16'd0, win_x} + 32'(STRIDE) + 32'(WIN)) <= 32'(IMG_W);
        fits_y    = ({16'd0, win_y} + 32'(STRIDE) + 32'(WIN)) <= 32'(IMG_H);
        frame_end = row_last && !fits_x && !fits_y;
        row_n     = row_idx;
        win_x_n   = win_x;
        win_y_n   = win_y;
        if (!row_last) begin
            row_n = row_idx + 5'd1;
        end else begin
            row_n = 5'd0;
            if (fits_x) begin
                win_x_n = win_x + STEP;
            end else if (fits_y) begin
                win_x_n = 16'd0;
                win_y_n = win_y + STEP;
            end
        end
        base_n = (MEM_AW'(win_y_n) + MEM_AW'(row_n)) * LINE_W + MEM_AW'(win_x_n);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. cls_done is looked at only in WAIT, so a done level
    // still high from the previous row cannot skip the KICK/WAIT handshake.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = READ;
            READ:    if (col == COL_LAST) state_n = DRAIN;
            DRAIN:   state_n = KICK;
            KICK:    state_n = WAIT;
            WAIT:    if (cls_done) state_n = ADVANCE;
            ADVANCE: state_n = frame_end ? FIN : READ;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Counters and row base. The base is registered so the read address is
    // a single add of the column counter during READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= 5'd0;
            row_idx <= 5'd0;
            win_x   <= 16'd0;
            win_y   <= 16'd0;
            base    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        col     <= 5'd0;
                        row_idx <= 5'd0;
                        win_x   <= 16'd0;
                        win_y   <= 16'd0;
                        base    <= '0;
                    end
                end
                READ: begin
                    col <= (col == COL_LAST) ? 5'd0 : col + 5'd1;
                end
                ADVANCE: begin
                    col     <= 5'd0;
                    row_idx <= row_n;
                    win_x   <= win_x_n;
                    win_y   <= win_y_n;
                    base    <= base_n;
                end
                default: begin
                end
            endcase
        end
    end

    // Write pipeline: memory data arrives one cycle after the read, so the
    // strobe and column of each read are delayed by one cycle to meet it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pending <= 1'b0;
            wr_col     <= 5'd0;
        end else begin
            wr_pending <= (state == READ);
            wr_col     <= (state == READ) ? col : 5'd0;
        end
    end

    // Output decode.
    always_comb begin
        mem_rd     = (state == READ);
        mem_addr   = mem_rd ? (base + MEM_AW'(col)) : '0;
        cls_we     = wr_pending;
        cls_addr   = 9'(wr_col);
        cls_xyz    = wr_pending ? mem_data : 96'd0;
        cls_start  = (state == KICK);
        busy       = (state != IDLE);
        frame_done = (state == FIN);
    end

endmodule

// File: doc/classifier_window_sequencer.md
Name: classifier_window_sequencer

Overview:
- Scan controller for the 20x20 integral-window classifier.
- Walks a window of WIN x WIN pixels across the frame in raster order with step STRIDE.
- For every window row it reads WIN 96-bit XYZ pixels from frame memory, writes them into the classifier line buffer at addresses 0..WIN-1, pulses the classifier start and waits for its done before loading the next row.
- Sits between the frame store and the classifier; the top level starts it once per frame.

Parameters:
- IMG_W, 640, frame width in pixels
- IMG_H, 480, frame height in pixels
- WIN, 20, window edge in pixels; equals classifier line-buffer depth
- STRIDE, 4, window step in pixels, both axes
- MEM_AW, 19, frame memory address width; must hold IMG_W*IMG_H-1

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  frame start request; sampled in IDLE only
- MEM_RD  out  1  frame memory read strobe
- MEM_ADDR  out  MEM_AW  pixel address, (win_y+row)*IMG_W + win_x + col
- MEM_DATA  in  96  read data, valid exactly 1 cycle after MEM_RD
- CLS_WE  out  1  line-buffer write strobe
- CLS_ADDR  out  9  line-buffer address, 0..WIN-1
- CLS_XYZ  out  96  line-buffer write data
- CLS_START  out  1  one-cycle pulse; a full row has been loaded
- CLS_DONE  in  1  classifier finished current row (level)
- WIN_X  out  16  current window left column
- WIN_Y  out  16  current window top row
- ROW_IDX  out  5  current row within window, 0..WIN-1
- BUSY  out  1  high in every state except IDLE
- FRAME_DONE  out  1  one-cycle pulse after the last row of the last window

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - column, row and window counters 0
- RESET is synchronous and overrides everything, including mid-row or mid-wait. The next cycle shows reset values and no pending strobes.
- States: IDLE, READ, DRAIN, KICK, WAIT, ADVANCE, FIN.
- IDLE:
  - START=1 clears WIN_X, WIN_Y, ROW_IDX and col, then goes to READ.
  - START in any other state is ignored.
- READ:
  - MEM_RD=1 with MEM_ADDR for col, col = 0..WIN-1 on consecutive cycles, no gaps.
  - After col = WIN-1 goes to DRAIN.
- Write path (registered):
  - In the cycle after each MEM_RD: CLS_WE=1, CLS_ADDR = that read's col, CLS_XYZ = MEM_DATA.
  - Writes therefore span READ cycles 2..WIN and DRAIN.
- DRAIN: last write (address WIN-1) occurs; MEM_RD=0. Goes to KICK.
- KICK: CLS_START=1 for exactly this cycle; CLS_WE=0. Goes to WAIT.
- WAIT:
  - Stays while CLS_DONE=0.
  - CLS_DONE is ignored in KICK, so a level left high from the previous row cannot skip a row.
  - CLS_DONE=1 goes to ADVANCE.
- ADVANCE (one cycle):
  - If ROW_IDX < WIN-1: ROW_IDX+1, col=0, go to READ.
  - Else ROW_IDX=0 and:
    - if WIN_X+STRIDE+WIN <= IMG_W: WIN_X += STRIDE
    - else if WIN_Y+STRIDE+WIN <= IMG_H: WIN_X=0, WIN_Y += STRIDE
    - else go to FIN
  - Goes to READ unless FIN.
- FIN: FRAME_DONE=1 for one cycle, BUSY=0 from the next cycle, then IDLE.
- Per-row latency from the first MEM_RD to CLS_START is WIN+2 cycles. Each row then costs WAIT time plus 1 ADVANCE cycle.
- Address arithmetic:
  - Row base is computed as (WIN_Y+ROW_IDX)*IMG_W + WIN_X, registered at ADVANCE / IDLE exit.
  - MEM_ADDR = base + col.
  - Result is MEM_AW bits and never exceeds IMG_W*IMG_H-1 by construction.
- Windows per frame: ((IMG_W-WIN)/STRIDE+1) * ((IMG_H-WIN)/STRIDE+1), integer division. If IMG_W<WIN or IMG_H<WIN the parameters are illegal; an elaboration assertion fires.
- WIN_X, WIN_Y and ROW_IDX hold stable from ADVANCE until the next ADVANCE, including through WAIT.

Test Plan:
- Reset values: assert RESET 3 cycles, then idle 5 cycles -> every output 0, BUSY=0, no MEM_RD.
- Single-row timing (IMG_W=24, IMG_H=22, WIN=20, STRIDE=4; memory returns data = address):
  - START at cycle 0 -> MEM_RD cycles 1..20 with MEM_ADDR 0..19.
  - CLS_WE cycles 2..21 with CLS_ADDR 0..19 and CLS_XYZ 0..19.
  - CLS_START only at cycle 22.
- Full frame (same parameters; CLS_DONE returned 3 cycles after each CLS_START) -> 40 CLS_START pulses.
  - Second window's row 0 reads MEM_ADDR 4..23; its row 19 reads 460..479.
  - Then WIN_X=4, WIN_Y=0, and exactly one FRAME_DONE.
- Sticky done: CLS_DONE held at 1 permanently -> still exactly one CLS_START per row, ADVANCE one cycle after KICK+1, no row skipped (40 pulses).
- Mid-operation reset: RESET asserted during WAIT of row 7 -> outputs zero next cycle. A new START restarts at MEM_ADDR 0, ROW_IDX 0.
- START during busy: pulse START in READ and in WAIT -> no restart, counters unaffected, frame completes with the same 40 rows.
